seq_divider_32by16: RTL
=======================

// Module: seq_divider_32by16
// PURPOSE
//  Iterative restoring divider and inverse of the 16x16->32 recursive multiplier datapath:
//  divides a 2*WIDTH-bit dividend by a WIDTH-bit divisor, yielding WIDTH-bit quotient and remainder.
//  Computes one quotient bit per clock behind valid/ready handshakes on input and output.
//  Sits next to the multiplier array for product checking and for normalisation/scaling
//  paths. Exact arithmetic only (no approximation).
// PARAMETERS
//  WIDTH   16   divisor/quotient/remainder width; dividend is 2*WIDTH bits
//  CNT_W   5    iteration counter width, must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk        in   1        single clock, all state updates on rising edge
//  rst_n      in   1        synchronous active-low reset
//  in_valid   in   1        dividend/divisor valid
//  in_ready   out  1        block can accept an operation
//  dividend   in   2*WIDTH  numerator, unsigned
//  divisor    in   WIDTH    denominator, unsigned
//  out_valid  out  1        result valid
//  out_ready  in   1        consumer accepts result
//  quotient   out  WIDTH    unsigned quotient
//  remainder  out  WIDTH    unsigned remainder
//  div_zero   out  1        divisor was 0
//  overflow   out  1        quotient does not fit WIDTH bits (dividend[2W-1:W] >= divisor, divisor!=0)
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): state IDLE; in_ready=1; out_valid=0; quotient, remainder,
//   div_zero, overflow = 0; counter = 0. Reset overrides every other event, including mid-RUN
//   and mid-DONE; any in-flight operation is discarded without output.
//  States: IDLE -> RUN -> DONE -> IDLE; IDLE -> DONE directly on error.
//  IDLE: in_ready=1, out_valid=0. Accept when in_valid&in_ready at an edge:
//   - divisor==0: -> DONE, div_zero=1, overflow=0, quotient=all-ones, remainder=dividend[W-1:0].
//   - else dividend[2W-1:W] >= divisor: -> DONE, overflow=1, div_zero=0, same fill values.
//   - else: R (WIDTH+1 bits) <= {1'b0, dividend[2W-1:W]}, Q <= dividend[W-1:0],
//     D <= divisor, counter <= 0, -> RUN. Flags cleared.
//  RUN: in_ready=0, out_valid=0. Each edge: {R,Q} shifted left 1; T = R_shift - {1'b0,D};
//   if T >= 0 (no borrow) R <= T and Q[0] <= 1, else R <= R_shift, Q[0] <= 0;
//   counter++. On the edge performing iteration WIDTH (counter==WIDTH-1) -> DONE.
//  DONE: out_valid=1, in_ready=0; quotient=Q, remainder=R[W-1:0]; all outputs held stable
//   while out_ready=0 (no limit on stall). out_valid&out_ready at an edge -> IDLE.
//   No new input is accepted in the same cycle as result handoff (in_ready=0 in DONE).
//  Latency: normal op out_valid first high WIDTH edges after accept edge (16 for default);
//   error op out_valid high 1 edge after accept edge. Throughput 1 op per WIDTH+2 cycles min.
//  Invariant in RUN: R < D after every iteration; R MSB exists only for the pre-subtract shift.
//  Outputs quotient/remainder/flags are registered; in_ready/out_valid are pure state decodes.
//  Inputs are sampled only on the accept edge; later changes to dividend/divisor are ignored.
//  in_valid may drop without acceptance (no requirement on the producer).
// TESTING
//  1) dividend=100, divisor=7 -> after 16 edges out_valid=1, quotient=14, remainder=2, flags 0.
//  2) dividend=0xFFFE0001, divisor=0xFFFF -> quotient=0xFFFF, remainder=0, overflow=0.
//  3) divisor=0, dividend=0x1234_5678 -> next cycle out_valid=1, div_zero=1, quotient=0xFFFF,
//     remainder=0x5678.
//  4) dividend=0x0007_0000, divisor=7 -> next cycle overflow=1, div_zero=0, quotient=0xFFFF.
//  5) Op 1 with out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0; then
//     out_ready=1 -> IDLE, in_ready=1 next cycle; second op accepted immediately.
//  6) rst_n=0 at RUN iteration 8 -> next cycle IDLE, out_valid=0, outputs 0; new op
//     dividend=1000, divisor=10 -> quotient=100, remainder=0.
//  Random: 10k ops vs reference model {q,r} = {dividend/divisor, dividend%divisor}, random stalls.

Source files
------------

// File: rtl/seq_divider_32by16.sv
// Iterative restoring divider: 2*WIDTH-bit unsigned dividend by WIDTH-bit divisor,
// one quotient bit per clock, valid/ready handshake on input and result.
module seq_divider_32by16 #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CNT_W = 5   // 2**CNT_W must exceed WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2*WIDTH-1:0]   dividend,
   input  logic [WIDTH-1:0]     divisor,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     quotient,
   output logic [WIDTH-1:0]     remainder,
   output logic                 div_zero,
   output logic                 overflow
);

   localparam int unsigned DW = 2 * WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state;
   logic [WIDTH-1:0]     rem_acc;   // partial remainder, always < div_reg between iterations
   logic [WIDTH-1:0]     quo_acc;   // low dividend bits shifting out, quotient bits shifting in
   logic [WIDTH-1:0]     div_reg;
   logic [CNT_W-1:0]     iter_cnt;

   logic [WIDTH-1:0]     div_hi;
   logic [WIDTH-1:0]     div_lo;
   logic [WIDTH:0]       rem_shift;
   logic [WIDTH:0]       rem_diff;
   logic                 take;
   logic [WIDTH-1:0]     rem_next;
   logic [WIDTH-1:0]     quo_next;

   // One restoring step. Since rem_acc < div_reg, the shifted value is below 2*div_reg,
   // so the difference fits WIDTH+1 bits signed and its MSB is the borrow.
   always_comb begin
      div_hi    = dividend[DW-1:WIDTH];
      div_lo    = dividend[WIDTH-1:0];
      rem_shift = {rem_acc, quo_acc[WIDTH-1]};
      rem_diff  = rem_shift - {1'b0, div_reg};
      take      = ~rem_diff[WIDTH];
      rem_next  = take ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
      quo_next  = {quo_acc[WIDTH-2:0], take};
   end

   // Control FSM, datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         div_zero  <= 1'b0;
         overflow  <= 1'b0;
         rem_acc   <= '0;
         quo_acc   <= '0;
         div_reg   <= '0;
         iter_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  if (divisor == '0) begin
                     state     <= DONE;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                     div_zero  <= 1'b1;
                     overflow  <= 1'b0;
                     quotient  <= '1;
                     remainder <= div_lo;
                  end else if (div_hi >= divisor) begin
                     state     <= DONE;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                     div_zero  <= 1'b0;
                     overflow  <= 1'b1;
                     quotient  <= '1;
                     remainder <= div_lo;
                  end else begin
                     state     <= RUN;
                     in_ready  <= 1'b0;
                     div_zero  <= 1'b0;
                     overflow  <= 1'b0;
                     rem_acc   <= div_hi;
                     quo_acc   <= div_lo;
                     div_reg   <= divisor;
                     iter_cnt  <= '0;
                  end
               end
            end
            RUN: begin
               rem_acc  <= rem_next;
               quo_acc  <= quo_next;
               iter_cnt <= iter_cnt + CNT_W'(1);
               if (iter_cnt == CNT_W'(WIDTH - 1)) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  quotient  <= quo_next;
                  remainder <= rem_next;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
